// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - execute-stage ALU issue, result capture, write-back and flags sequencer
//
// Purpose:
//    Accepts one decoded ALU operation per req_valid/req_ready handshake,
//    latches its operands and drives them to the ALU. It strobes alu_en for
//    two cycles and captures the results and flag vector. It then writes
//    o1 (and o2 for MUL/IMUL/DIV/IDIV) back to the register file and
//    updates the architectural flags register. A divide with a zero divisor
//    is never issued and raises a single-cycle div_fault instead.
//
// Ports:
//    clk, rst_n            clock (rising edge), asynchronous active-low reset
//    req_*                 decoded operation from decode/regfile-read
//    alu_a/b/func/size/en  registered operation and strobe to the ALU
//    alu_o1/o2/flag        ALU results, valid while alu_en is high
//    wb_we/idx/data        register-file write port
//    flags                 architectural flags register
//    busy                  high whenever the sequencer is not idle
//    div_fault             one-cycle pulse on divide-by-zero
//    op_count, fault_count saturating statistics (ALU_ISSUE_STATS_EN only)
//
// Optional feature macro: ALU_ISSUE_STATS_EN

module alu_issue_ctrl #(
   parameter int WB_IDX_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [4:0]          req_func,
   input  logic                req_size,
   input  logic [31:0]         req_a,
   input  logic [31:0]         req_b,
   input  logic [WB_IDX_W-1:0] req_dst1,
   input  logic [WB_IDX_W-1:0] req_dst2,
   output logic [31:0]         alu_a,
   output logic [31:0]         alu_b,
   output logic [4:0]          alu_func,
   output logic                alu_size,
   output logic                alu_en,
   input  logic [15:0]         alu_o1,
   input  logic [15:0]         alu_o2,
   input  logic [15:0]         alu_flag,
   output logic                wb_we,
   output logic [WB_IDX_W-1:0] wb_idx,
   output logic [15:0]         wb_data,
   output logic [15:0]         flags,
   output logic                busy,
   output logic                div_fault
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0]         op_count,
   output logic [7:0]          fault_count
`endif
);

   // ALU opcode encoding shared with the ALU
   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_NEG  = 5'd2;
   localparam logic [4:0] ALU_MUL  = 5'd3;
   localparam logic [4:0] ALU_IMUL = 5'd4;
   localparam logic [4:0] ALU_AND  = 5'd5;
   localparam logic [4:0] ALU_OR   = 5'd6;
   localparam logic [4:0] ALU_XOR  = 5'd7;
   localparam logic [4:0] ALU_SHL  = 5'd8;
   localparam logic [4:0] ALU_SHR  = 5'd9;
   localparam logic [4:0] ALU_SAR  = 5'd10;
   localparam logic [4:0] ALU_ROL  = 5'd11;
   localparam logic [4:0] ALU_ROR  = 5'd12;
   localparam logic [4:0] ALU_INC  = 5'd13;
   localparam logic [4:0] ALU_DEC  = 5'd14;
   localparam logic [4:0] ALU_NOT  = 5'd15;
   localparam logic [4:0] ALU_DIV  = 5'd16;
   localparam logic [4:0] ALU_IDIV = 5'd17;

   // Flag bit positions within alu_flag / flags
   localparam int ALUF_CF = 0;
   localparam int ALUF_ZF = 6;
   localparam int ALUF_SF = 7;
   localparam int ALUF_OF = 11;

   localparam logic [15:0] FLAGS_ARITH = (16'd1 << ALUF_CF) | (16'd1 << ALUF_OF) |
                                         (16'd1 << ALUF_ZF) | (16'd1 << ALUF_SF);
   localparam logic [15:0] FLAGS_INCDEC = (16'd1 << ALUF_ZF) | (16'd1 << ALUF_SF);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_CAPT  = 3'd2,
      S_WB1   = 3'd3,
      S_WB2   = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t                r_state;
   logic                  r_req_ready;
   logic [31:0]           r_alu_a;
   logic [31:0]           r_alu_b;
   logic [4:0]            r_alu_func;
   logic                  r_alu_size;
   logic                  r_alu_en;
   logic [WB_IDX_W-1:0]   r_dst1;
   logic [WB_IDX_W-1:0]   r_dst2;
   logic [15:0]           r_o2;
   logic                  r_wb_we;
   logic [WB_IDX_W-1:0]   r_wb_idx;
   logic [15:0]           r_wb_data;
   logic [15:0]           r_flags;
   logic                  r_busy;
   logic                  r_div_fault;

   logic                  w_div_zero;
   logic                  w_two_result;
   logic [15:0]           w_flag_mask;
   logic [15:0]           w_o1_wb;
   logic [15:0]           w_o2_wb;

   // Divisor is checked on the incoming request so a zero divide never
   // reaches the ALU; only the operand width's low bits matter.
   always_comb begin
      w_div_zero = 1'b0;
      if ((req_func == ALU_DIV) || (req_func == ALU_IDIV)) begin
         w_div_zero = req_size ? (req_a[15:0] == 16'h0000) : (req_a[7:0] == 8'h00);
      end
   end

   always_comb begin
      w_two_result = 1'b0;
      case (r_alu_func)
         ALU_MUL, ALU_IMUL, ALU_DIV, ALU_IDIV: w_two_result = 1'b1;
         default:                              w_two_result = 1'b0;
      endcase
   end

   // Which architectural flag bits the latched op is allowed to overwrite.
   // NOT, DIV, IDIV and unassigned opcodes leave the flags untouched.
   always_comb begin
      w_flag_mask = 16'h0000;
      case (r_alu_func)
         ALU_ADD, ALU_SUB, ALU_NEG, ALU_MUL, ALU_IMUL,
         ALU_AND, ALU_OR, ALU_XOR,
         ALU_SHL, ALU_SHR, ALU_SAR, ALU_ROL, ALU_ROR: w_flag_mask = FLAGS_ARITH;
         ALU_INC, ALU_DEC:                           w_flag_mask = FLAGS_INCDEC;
         default:                                     w_flag_mask = 16'h0000;
      endcase
   end

   // Byte ops write back a zero-extended byte.
   always_comb begin
      w_o1_wb = r_alu_size ? alu_o1 : {8'h00, alu_o1[7:0]};
      w_o2_wb = r_alu_size ? alu_o2 : {8'h00, alu_o2[7:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_alu_a     <= 32'h0;
         r_alu_b     <= 32'h0;
         r_alu_func  <= 5'h0;
         r_alu_size  <= 1'b0;
         r_alu_en    <= 1'b0;
         r_dst1      <= '0;
         r_dst2      <= '0;
         r_o2        <= 16'h0;
         r_wb_we     <= 1'b0;
         r_wb_idx    <= '0;
         r_wb_data   <= 16'h0;
         r_flags     <= 16'h0;
         r_busy      <= 1'b0;
         r_div_fault <= 1'b0;
      end else begin
         r_div_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_alu_a     <= req_a;
                  r_alu_b     <= req_b;
                  r_alu_func  <= req_func;
                  r_alu_size  <= req_size;
                  r_dst1      <= req_dst1;
                  r_dst2      <= req_dst2;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_div_zero) begin
                     r_div_fault <= 1'b1;
                     r_state     <= S_FAULT;
                  end else begin
                     r_alu_en    <= 1'b1;
                     r_state     <= S_ISSUE;
                  end
               end
            end

            // en held through CAPT because ALU outputs are only valid while
            // en is high.
            S_ISSUE: begin
               r_state <= S_CAPT;
            end

            S_CAPT: begin
               r_alu_en  <= 1'b0;
               r_flags   <= (r_flags & ~w_flag_mask) | (alu_flag & w_flag_mask);
               r_o2      <= w_o2_wb;
               r_wb_we   <= 1'b1;
               r_wb_idx  <= r_dst1;
               r_wb_data <= w_o1_wb;
               r_state   <= S_WB1;
            end

            S_WB1: begin
               if (w_two_result) begin
                  r_wb_idx  <= r_dst2;
                  r_wb_data <= r_o2;
                  r_state   <= S_WB2;
               end else begin
                  r_wb_we     <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            S_WB2: begin
               r_wb_we     <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end

            S_FAULT: begin
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end

            default: begin
               r_alu_en    <= 1'b0;
               r_wb_we     <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_func  = r_alu_func;
   assign alu_size  = r_alu_size;
   assign alu_en    = r_alu_en;
   assign wb_we     = r_wb_we;
   assign wb_idx    = r_wb_idx;
   assign wb_data   = r_wb_data;
   assign flags     = r_flags;
   assign busy      = r_busy;
   assign div_fault = r_div_fault;

`ifdef ALU_ISSUE_STATS_EN
   logic [15:0] r_op_count;
   logic [7:0]  r_fault_count;

   // An op is counted on its ISSUE->CAPT step, a fault while in FAULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count    <= 16'h0;
         r_fault_count <= 8'h0;
      end else begin
         if ((r_state == S_ISSUE) && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
         end
         if ((r_state == S_FAULT) && (r_fault_count != 8'hFF)) begin
            r_fault_count <= r_fault_count + 8'd1;
         end
      end
   end

   assign op_count    = r_op_count;
   assign fault_count = r_fault_count;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a stub ALU

module tb_alu_issue_ctrl;

   localparam int W = 3;

   localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  NEG = 5'd2,  MUL = 5'd3,  IMUL = 5'd4;
   localparam logic [4:0] AND_ = 5'd5, OR_ = 5'd6,  XOR_ = 5'd7, SHL = 5'd8,  SHR = 5'd9;
   localparam logic [4:0] SAR = 5'd10, ROL = 5'd11, ROR = 5'd12, INC = 5'd13, DEC = 5'd14;
   localparam logic [4:0] NOT_ = 5'd15, DIV = 5'd16, IDIV = 5'd17;
   localparam int CF = 0, ZF = 6, SF = 7, OF = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [4:0]    req_func = 5'd0;
   logic          req_size = 1'b0;
   logic [31:0]   req_a = 32'd0;
   logic [31:0]   req_b = 32'd0;
   logic [W-1:0]  req_dst1 = '0;
   logic [W-1:0]  req_dst2 = '0;
   logic [31:0]   alu_a, alu_b;
   logic [4:0]    alu_func;
   logic          alu_size, alu_en;
   logic [15:0]   alu_o1, alu_o2, alu_flag;
   logic          wb_we;
   logic [W-1:0]  wb_idx;
   logic [15:0]   wb_data, flags;
   logic          busy, div_fault;
`ifdef ALU_ISSUE_STATS_EN
   logic [15:0]   op_count;
   logic [7:0]    fault_count;
`endif

   always #5 clk = ~clk;

   alu_issue_ctrl #(.WB_IDX_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func), .req_size(req_size),
      .req_a(req_a), .req_b(req_b), .req_dst1(req_dst1), .req_dst2(req_dst2),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_size(alu_size), .alu_en(alu_en),
      .alu_o1(alu_o1), .alu_o2(alu_o2), .alu_flag(alu_flag),
      .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data), .flags(flags),
      .busy(busy), .div_fault(div_fault)
`ifdef ALU_ISSUE_STATS_EN
      , .op_count(op_count), .fault_count(fault_count)
`endif
   );

   // Stub ALU: exact arithmetic for ADD/SUB/INC/MUL, a deterministic hash
   // otherwise. Garbage in unused high bytes and flag bits exercises masking.
   function automatic logic [47:0] alu_fn(input logic [4:0] f, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [31:0] h, p;
      logic [16:0] aa, bb, r;
      logic [15:0] o1, o2, fl;
      logic sa, sb, sr, c;
      h  = (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ {27'd0, f} ^ {31'd0, s};
      o1 = h[31:16];
      o2 = h[15:0] ^ 16'h5A5A;
      fl = h[15:0] ^ h[31:16];
      aa = s ? {1'b0, a[15:0]} : {9'd0, a[7:0]};
      bb = s ? {1'b0, b[15:0]} : {9'd0, b[7:0]};
      if (f == ADD || f == SUB || f == INC) begin
         if (f == ADD)      r = aa + bb;
         else if (f == SUB) r = aa - bb;
         else               r = aa + 17'd1;
         sa = s ? aa[15] : aa[7];
         sb = s ? bb[15] : bb[7];
         sr = s ? r[15] : r[7];
         if (f == ADD)      fl[OF] = (sa == sb) && (sr != sa);
         else if (f == SUB) fl[OF] = (sa != sb) && (sr != sa);
         else               fl[OF] = !sa && sr;
         fl[CF] = s ? r[16] : r[8];
         fl[ZF] = s ? (r[15:0] == 16'h0) : (r[7:0] == 8'h0);
         fl[SF] = sr;
         o1 = s ? r[15:0] : {h[7:0], r[7:0]};
      end else if (f == MUL) begin
         p = {16'd0, aa[15:0]} * {16'd0, bb[15:0]};
         if (s) begin
            o1 = p[15:0]; o2 = p[31:16]; c = |p[31:16];
         end else begin
            o1 = {h[7:0], p[7:0]}; o2 = {h[15:8], p[15:8]}; c = |p[15:8];
         end
         fl[CF] = c;
         fl[OF] = c;
      end
      return {fl, o2, o1};
   endfunction

   logic [47:0] stub_r;
   always_comb begin
      stub_r = alu_fn(alu_func, alu_size, alu_a, alu_b);
      if (alu_en) {alu_flag, alu_o2, alu_o1} = stub_r;
      else        {alu_flag, alu_o2, alu_o1} = 48'hDEAD_BEEF_F00D;
   end

   // Reference model state
   typedef struct {
      int          idx;
      logic [15:0] data;
      logic [15:0] flg;
      int          at_edge;
   } wb_t;

   wb_t         wq[$];
   int          fq[$];
   logic [15:0] m_flags = 16'h0;
   int          m_ops = 0, m_faults = 0, n_issued = 0;
   int          vectors = 0, miscompares = 0;
   int          cyc = 0, en_seen = 0, wb_seen = 0, faults_seen = 0;
   int          last_n = 0, last_int = 0;
   bit          held = 0;
   int          last_idx = 0;
   logic [15:0] last_data = 16'h0;
   wb_t         mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] model_mask(input logic [4:0] f);
      if (f inside {ADD, SUB, NEG, MUL, IMUL, AND_, OR_, XOR_, SHL, SHR, SAR, ROL, ROR})
         return (16'd1 << CF) | (16'd1 << OF) | (16'd1 << ZF) | (16'd1 << SF);
      if (f inside {INC, DEC})
         return (16'd1 << ZF) | (16'd1 << SF);
      return 16'h0;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT writes back or faults.
   always @(negedge clk) begin
      if (rst_n) begin
         if (alu_en) en_seen++;
         if (wb_we) begin
            wb_seen++;
            last_idx  = int'(wb_idx);
            last_data = wb_data;
            if (wq.size() == 0) begin
               chk("unexpected_wb", {29'd0, wb_idx}, 32'hFFFF_FFFF);
            end else begin
               mon_e = wq.pop_front();
               chk("wb_idx", {29'd0, wb_idx}, mon_e.idx);
               chk("wb_data", {16'd0, wb_data}, {16'd0, mon_e.data});
               chk("wb_flags", {16'd0, flags}, {16'd0, mon_e.flg});
               chk("wb_edge", cyc + 1, mon_e.at_edge);
            end
         end
         if (div_fault) begin
            faults_seen++;
            if (fq.size() == 0) chk("unexpected_fault", cyc, 32'hFFFF_FFFF);
            else                chk("fault_edge", cyc, fq.pop_front());
         end
      end
   end

   task automatic chk_reset();
      chk("rst_ready", req_ready, 1);
      chk("rst_alu_en", alu_en, 0);
      chk("rst_wb_we", wb_we, 0);
      chk("rst_div_fault", div_fault, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_func", {27'd0, alu_func}, 0);
      chk("rst_alu_size", alu_size, 0);
      chk("rst_wb_idx", {29'd0, wb_idx}, 0);
      chk("rst_wb_data", {16'd0, wb_data}, 0);
      chk("rst_flags", {16'd0, flags}, 0);
`ifdef ALU_ISSUE_STATS_EN
      chk("rst_op_count", {16'd0, op_count}, 0);
      chk("rst_fault_count", {24'd0, fault_count}, 0);
`endif
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic do_op(input logic [4:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int d1, input int d2);
      int          wc, n;
      logic [47:0] r;
      logic [15:0] o1, o2, fl;
      bit          zero, two;
      req_valid = 1'b1; req_func = f; req_size = s; req_a = a; req_b = b;
      req_dst1 = d1[W-1:0]; req_dst2 = d2[W-1:0];
      wc = 0;
      while (!req_ready && wc < 50) begin
         @(negedge clk);
         wc++;
      end
      if (!req_ready) begin
         chk("accept_timeout", wc, 0);
         req_valid = 1'b0;
         return;
      end
      n    = cyc + 1;
      zero = (f == DIV || f == IDIV) && (s ? (a[15:0] == 16'h0) : (a[7:0] == 8'h0));
      two  = (f == MUL || f == IMUL || f == DIV || f == IDIV);
      if (held) chk("issue_interval", n - last_n, last_int);
      last_n   = n;
      last_int = zero ? 2 : (two ? 5 : 4);
      held     = 1;
      if (zero) begin
         fq.push_back(n);
         m_faults++;
      end else begin
         r  = alu_fn(f, s, a, b);
         o1 = r[15:0]; o2 = r[31:16]; fl = r[47:32];
         m_flags = (m_flags & ~model_mask(f)) | (fl & model_mask(f));
         wq.push_back('{d1, s ? o1 : {8'h00, o1[7:0]}, m_flags, n + 3});
         if (two) wq.push_back('{d2, s ? o2 : {8'h00, o2[7:0]}, m_flags, n + 4});
         m_ops++;
         n_issued++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("ready_low_after_accept", req_ready, 0);
      chk("busy_after_accept", busy, 1);
   endtask

   task automatic idle(input int k);
      req_valid = 1'b0;
      repeat (k) @(negedge clk);
      if (k > 0) held = 0;
   endtask

   task automatic drain();
      int wc = 0;
      while ((wq.size() != 0 || fq.size() != 0 || !req_ready) && wc < 30) begin
         @(negedge clk);
         wc++;
      end
      if (wc >= 30) chk("drain_timeout", wc, 0);
      held = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          en0, wb0, f0;
      logic [4:0]  f;
      logic        s;
      logic [31:0] a;

      #12;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD 7FFF + 1, size 16
      en0 = en_seen; wb0 = wb_seen;
      do_op(ADD, 1'b1, 32'h7FFF, 32'h0001, 2, 0);
      drain();
      chk("add_en_cycles", en_seen - en0, 2);
      chk("add_wb_count", wb_seen - wb0, 1);
      chk("add_wb_idx", last_idx, 2);
      chk("add_wb_data", {16'd0, last_data}, 32'h8000);
      chk("add_flags_of_sf_zf_cf", {28'd0, flags[OF], flags[SF], flags[ZF], flags[CF]}, 4'b1100);

      // MUL FFFF * FFFF, size 16
      wb0 = wb_seen;
      do_op(MUL, 1'b1, 32'hFFFF, 32'hFFFF, 1, 3);
      drain();
      chk("mul_wb_count", wb_seen - wb0, 2);
      chk("mul_wb2_idx", last_idx, 3);
      chk("mul_wb2_data", {16'd0, last_data}, 32'hFFFE);
      chk("mul_cf_of", {30'd0, flags[CF], flags[OF]}, 2'b11);

      // DIV by zero, size 8
      en0 = en_seen; wb0 = wb_seen; f0 = faults_seen;
      do_op(DIV, 1'b0, 32'h0, 32'h0100, 4, 5);
      drain();
      chk("div0_fault_count", faults_seen - f0, 1);
      chk("div0_no_en", en_seen - en0, 0);
      chk("div0_no_wb", wb_seen - wb0, 0);
      chk("div0_flags_kept", {16'd0, flags}, {16'd0, m_flags});

      // SUB 0-1 then INC FF, size 8: CF survives INC
      do_op(SUB, 1'b0, 32'h0, 32'h1, 4, 0);
      drain();
      chk("sub_cf", flags[CF], 1);
      do_op(INC, 1'b0, 32'hFF, 32'h0, 5, 0);
      drain();
      chk("inc_wb_data", {16'd0, last_data}, 32'h0000);
      chk("inc_zf", flags[ZF], 1);
      chk("inc_cf_kept", flags[CF], 1);

      // Reset during CAPT of an ADD
      do_op(ADD, 1'b1, 32'h1234, 32'h1111, 6, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset();
      wq.delete();
      fq.delete();
      m_flags = 16'h0; m_ops = 0; m_faults = 0; held = 0;
      @(negedge clk);
      rst_n = 1'b1;
      wb0 = wb_seen;
      idle(5);
      chk("no_wb_after_reset", wb_seen - wb0, 0);
      do_op(ADD, 1'b1, 32'h0001, 32'h0002, 7, 0);
      drain();
      chk("post_reset_wb_idx", last_idx, 7);
      chk("post_reset_wb_data", {16'd0, last_data}, 32'h0003);

      // Randomised traffic, mostly back-to-back
      for (int i = 0; i < 250; i++) begin
         case ($urandom_range(0, 9))
            0:       f = 5'($urandom_range(18, 31));
            1, 2:    f = ($urandom_range(0, 1) != 0) ? DIV : IDIV;
            default: f = 5'($urandom_range(0, 17));
         endcase
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         if (f == DIV || f == IDIV) begin
            case ($urandom_range(0, 3))
               0:       a[7:0] = 8'h00;
               1:       a[15:0] = 16'h0000;
               default: ;
            endcase
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         do_op(f, s, a, $urandom, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      drain();

      chk("wq_empty", wq.size(), 0);
      chk("fq_empty", fq.size(), 0);
      chk("en_cycles_total", en_seen, 2 * n_issued);
      chk("final_flags", {16'd0, flags}, {16'd0, m_flags});
`ifdef ALU_ISSUE_STATS_EN
      chk("op_count", {16'd0, op_count}, (m_ops > 65535) ? 65535 : m_ops);
      chk("fault_count", {24'd0, fault_count}, (m_faults > 255) ? 255 : m_faults);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer that drives the ALU from the initiator side: accepts one decoded operation per handshake, latches operands, and produces the ALU `en` strobe.
- Captures the ALU results and flag vector, writes results back to the register file, and maintains the architectural flags register.
- Sits between decode/regfile-read and the ALU/regfile-write.
- Detects divide-by-zero before issue and faults instead of issuing.

Parameters:
- WB_IDX_W, 3, width of register-file write index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  decode presents an operation.
- req_ready  out  1  controller can accept (IDLE only).
- req_func  in  5  `ALU_* opcode from defines.v.
- req_size  in  1  0 = 8-bit op, 1 = 16-bit op.
- req_a  in  32  operand a (divisor for DIV/IDIV).
- req_b  in  32  operand b (dividend for DIV/IDIV, full 2*SIZE).
- req_dst1  in  WB_IDX_W  write index for o1.
- req_dst2  in  WB_IDX_W  write index for o2 (MUL/IMUL/DIV/IDIV only).
- alu_a  out  32  registered operand to ALU.
- alu_b  out  32  registered operand to ALU.
- alu_func  out  5  registered opcode.
- alu_size  out  1  registered size.
- alu_en  out  1  ALU strobe.
- alu_o1  in  16  ALU result low.
- alu_o2  in  16  ALU result high / remainder.
- alu_flag  in  16  ALU flag vector.
- wb_we  out  1  register-file write strobe.
- wb_idx  out  WB_IDX_W  write index.
- wb_data  out  16  write data; for size 0, bits 15:8 are 0.
- flags  out  16  architectural flags register.
- busy  out  1  high in any state other than IDLE.
- div_fault  out  1  one-cycle pulse on divide-by-zero.

Behaviour:
- Reset values (async, rst_n low):
  - State = IDLE.
  - alu_en, wb_we, div_fault, busy = 0; req_ready = 1.
  - alu_a, alu_b, alu_func, alu_size, wb_idx, wb_data, flags = 0.
- States: IDLE, ISSUE, CAPT, WB1, WB2, FAULT.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all req_* fields.
  - If func is DIV/IDIV and the divisor is zero (a[7:0] for size 0, a[15:0] for size 1), go to FAULT; otherwise go to ISSUE.
- ISSUE: alu_en = 1 (rising edge of en launches ALU). Next state is CAPT.
- CAPT:
  - alu_en stays 1 (ALU outputs are valid only while en is high).
  - At the end of the cycle, sample alu_o1, alu_o2 and alu_flag, and update flags per the class rules below.
  - Next state is WB1.
- WB1:
  - alu_en = 0.
  - wb_we = 1, wb_idx = dst1, wb_data = o1 (masked to 8 bits for size 0).
  - Next state is WB2 for MUL/IMUL/DIV/IDIV, else IDLE.
- WB2: wb_we = 1, wb_idx = dst2, wb_data = o2 (masked). Next state is IDLE.
- FAULT: div_fault = 1 for exactly one cycle; no ALU issue, no write-back, flags unchanged. Next state is IDLE.
- Flag update classes, using `ALUF_CF/OF/ZF/SF:
  - ADD, SUB, NEG, MUL, IMUL, AND, OR, XOR, shifts, rotates: copy CF, OF, ZF, SF from alu_flag.
  - INC, DEC: copy ZF and SF; CF and OF are preserved.
  - NOT, DIV, IDIV: flags unchanged.
  - All other flag bits are always preserved.
- Latency and throughput:
  - Request accepted at edge N. Write of o1 occurs at edge N+3; o2 at N+4.
  - Minimum issue interval: 4 cycles (single-result ops) or 5 cycles (two-result ops).
  - alu_en is always low for at least 2 cycles between operations, guaranteeing a fresh posedge.
- Invalid or unassigned func: issued normally; write-back of o1 only; flags unchanged.
- Reset asserted mid-operation: immediately returns to IDLE with all outputs at reset values. The pending write-back is dropped.
- Back-to-back request: req_valid held high during busy is ignored until IDLE; the request is accepted on the first IDLE cycle.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined:
  - Adds output `op_count` (16): increments once per operation reaching CAPT, saturating at 16'hFFFF.
  - Adds output `fault_count` (8): increments per FAULT, saturating at 8'hFF.
  - Both counters reset to 0 with rst_n.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- ADD, size 1, a=16'h7FFF, b=16'h0001, dst1=2:
  - alu_en is high for exactly 2 cycles.
  - wb_we at N+3 with idx 2, data 16'h8000.
  - flags: OF=1, SF=1, ZF=0, CF=0.
  - No WB2.
- MUL, size 1, a=16'hFFFF, b=16'hFFFF, dst1=1, dst2=3:
  - WB1 writes idx 1, data 16'h0001; WB2 writes idx 3, data 16'hFFFE.
  - CF=OF=1.
  - req_ready is low from N+1 to N+4.
- DIV, size 0, a=0, b=16'h0100:
  - div_fault pulses 1 cycle at N+1.
  - alu_en never rises; no wb_we; flags unchanged; req_ready is back at N+2.
- Flag preservation: SUB 0-1 (size 0) sets CF=1, then INC of a=8'hFF:
  - wb_data = 16'h0000.
  - ZF=1, CF stays 1.
- rst_n driven low during CAPT of an ADD:
  - All outputs go to reset values asynchronously; no wb_we follows.
  - The next request after release completes normally.
- Stats enabled: 3 valid ops plus 1 divide-by-zero → op_count=3, fault_count=1.
